datapath_controller: RTL
========================

// Module: datapath_controller
// PURPOSE
//  Multi-cycle control unit that sequences the 16-bit datapath (register file, ALU, mux, data memory).
//  Fetches 16-bit instructions from a synchronous instruction ROM, decodes them and drives every datapath control line.
//  Sits between instruction memory and the datapath; together they form the processor top level.
// PARAMETERS
//  PC_W      7     program counter / instruction address width (128-word ROM)
//  ALU_PASS  3'd0  Alu_s0 code driven when no ALU operation is active
//  ALU_ADD   3'd1  Alu_s0 code for A+B
//  ALU_SUB   3'd2  Alu_s0 code for A-B
// PORTS
//  clk         in   1     rising-edge clock, shared with the datapath
//  rst_n       in   1     asynchronous, active-low reset
//  I_data      in   16    instruction ROM read data; valid 1 cycle after I_addr/I_rd
//  I_addr      out  PC_W  instruction ROM address (equals PC)
//  I_rd        out  1     instruction ROM read strobe
//  D_Addr      out  8     data memory address
//  D_wr        out  1     data memory write enable
//  RF_s        out  1     write-back mux select: 0=ALU, 1=data memory
//  RF_W_addr   out  4     register file write address
//  RF_W_en     out  1     register file write enable
//  RF_Ra_addr  out  4     register file read port A address
//  RF_Rb_addr  out  4     register file read port B address
//  Alu_s0      out  3     ALU operation select
//  PC          out  PC_W  program counter (debug)
//  IR          out  16    instruction register (debug)
//  state       out  4     current FSM state encoding (debug)
//  halted      out  1     high while in HALT
// BEHAVIOUR
//  - Instruction format: op=IR[15:12]. NOOP=0, STORE=1, LOAD=2, ADD=3, SUB=4, HALT=5; ops 6-15 decode as NOOP.
//    STORE: mem[IR[11:4]] <= R[IR[3:0]]    LOAD: R[IR[3:0]] <= mem[IR[11:4]]
//    ADD/SUB: R[IR[3:0]] <= R[IR[11:8]] +/- R[IR[7:4]]
//  - Reset (async assert, sync release): state=INIT, PC=0, IR=0. All control outputs 0, Alu_s0=ALU_PASS, halted=0.
//  - States: INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
//  - INIT: all outputs idle; unconditionally -> FETCH next cycle.
//  - FETCH: I_rd=1, I_addr=PC; PC <= PC+1 on exit; -> DECODE. PC wraps 2^PC_W-1 -> 0 with no flag.
//  - DECODE: IR <= I_data; next state chosen from I_data[15:12]: NOOP/undefined->FETCH, 1->STORE, 2->LOAD_A,
//    3->ADD, 4->SUB, 5->HALT. Control outputs idle.
//  - STORE: D_Addr=IR[11:4], RF_Ra_addr=IR[3:0], D_wr=1 for exactly this cycle; -> FETCH.
//  - LOAD_A: D_Addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=0 (memory read latency); -> LOAD_B.
//  - LOAD_B: same as LOAD_A but RF_W_en=1; -> FETCH.
//  - ADD/SUB: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_s=0, RF_W_en=1,
//    Alu_s0=ALU_ADD/ALU_SUB; -> FETCH.
//  - HALT: halted=1, all controls idle, PC frozen; exits only through rst_n.
//  - Outputs not owned by the current state are 0 (Alu_s0=ALU_PASS). D_wr and RF_W_en are never both 1.
//    All control outputs are a Moore decode of state and IR.
//  - Cycles per instruction: NOOP 2, STORE/ADD/SUB 3, LOAD 4, HALT 2, then stays in HALT.
//  - rst_n asserted mid-instruction aborts it immediately: D_wr/RF_W_en drop asynchronously and no
//    partial write occurs after the assertion.
//  - Undefined state encodings recover to INIT.
// TESTING
//  1. Reset then ROM[0]=16'h0000 (NOOP): state INIT->FETCH->DECODE->FETCH; PC=1 after 3 clks; no D_wr or RF_W_en.
//  2. ROM[0]=16'h2055 (LOAD): LOAD_A has D_Addr=8'h05, RF_W_en=0; LOAD_B has RF_s=1, RF_W_addr=5, RF_W_en=1.
//  3. ROM[0]=16'h3123 (ADD): one cycle with Ra=1, Rb=2, W_addr=3, Alu_s0=ALU_ADD, RF_W_en=1.
//     ROM[1]=16'h4123 (SUB): same with Alu_s0=ALU_SUB.
//  4. ROM[0]=16'h1A36 (STORE): one cycle with D_Addr=8'hA3, RF_Ra_addr=6, D_wr=1; D_wr=0 on all other cycles.
//  5. ROM[0]=16'h5000 (HALT): halted=1 and PC=1 held for 20 clks. Then rst_n pulse -> PC=0, halted=0.
//  6. rst_n low during LOAD_A -> state=INIT and all enables 0 at once. PC wrap: PC=127, NOOP -> PC=0.

Source files
------------

// File: rtl/datapath_controller.sv
// Multi-cycle control unit for the 16-bit datapath.
// Fetches from a synchronous ROM, decodes, and drives all datapath controls.
module datapath_controller #(
  parameter int          PC_W     = 7,
  parameter logic [2:0]  ALU_PASS = 3'd0,
  parameter logic [2:0]  ALU_ADD  = 3'd1,
  parameter logic [2:0]  ALU_SUB  = 3'd2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     I_data,
  output logic [PC_W-1:0] I_addr,
  output logic            I_rd,
  output logic [7:0]      D_Addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      Alu_s0,
  output logic [PC_W-1:0] PC,
  output logic [15:0]     IR,
  output logic [3:0]      state,
  output logic            halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  state_t          st_q;
  state_t          st_d;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [3:0]      op;

  assign op = I_data[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= S_INIT;
    end else begin
      st_q <= st_d;
    end
  end

  // PC advances when leaving FETCH; IR captures ROM data in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      if (st_q == S_FETCH) begin
        pc_q <= pc_q + PC_W'(1);
      end
      if (st_q == S_DECODE) begin
        ir_q <= I_data;
      end
    end
  end

  always_comb begin
    st_d = S_INIT;
    case (st_q)
      S_INIT:   st_d = S_FETCH;
      S_FETCH:  st_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == 4'd1): st_d = S_STORE;
          (op == 4'd2): st_d = S_LOAD_A;
          (op == 4'd3): st_d = S_ADD;
          (op == 4'd4): st_d = S_SUB;
          (op == 4'd5): st_d = S_HALT;
          default:      st_d = S_FETCH;
        endcase
      end
      S_LOAD_A: st_d = S_LOAD_B;
      S_LOAD_B: st_d = S_FETCH;
      S_STORE:  st_d = S_FETCH;
      S_ADD:    st_d = S_FETCH;
      S_SUB:    st_d = S_FETCH;
      S_HALT:   st_d = S_HALT;
      default:  st_d = S_INIT;
    endcase
  end

  always_comb begin
    I_rd       = 1'b0;
    D_Addr     = 8'd0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'd0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'd0;
    RF_Rb_addr = 4'd0;
    Alu_s0     = ALU_PASS;
    halted     = 1'b0;
    case (st_q)
      S_FETCH: I_rd = 1'b1;
      S_STORE: begin
        D_Addr     = ir_q[11:4];
        RF_Ra_addr = ir_q[3:0];
        D_wr       = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = ir_q[11:4];
        RF_s      = 1'b1;
        RF_W_addr = ir_q[3:0];
        RF_W_en   = (st_q == S_LOAD_B);
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir_q[11:8];
        RF_Rb_addr = ir_q[7:4];
        RF_W_addr  = ir_q[3:0];
        RF_W_en    = 1'b1;
        Alu_s0     = (st_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign I_addr = pc_q;
  assign PC     = pc_q;
  assign IR     = ir_q;
  assign state  = st_q;

endmodule
